// File: rtl/amp_bank_reader.sv
// amp_bank_reader: read-side sequencer for the signed amplitude register bank.
// A start pulse walks every bank address with synchronous reads. The returned
// words go out unmodified on a valid/ready stream, and m_last marks the final
// beat of the pass. A 2-entry output buffer plus credit-based read issue lets
// the stream absorb backpressure without losing or duplicating a word.
//
// Optional build macro READOUT_BITREV_EN: drives rd_addr with the bit-reversed
// issue counter, so QFT results stream in natural frequency order. The default
// build reads the bank in linear order 0..DEPTH-1.
module amp_bank_reader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    // Elaboration guard on the bank geometry.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (ADDR_W != $clog2(DEPTH))) begin : g_bad_geometry
        $error("amp_bank_reader: DEPTH must be a power of two >= 2 and ADDR_W must equal log2(DEPTH)");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   issue_cnt_r;
    logic                inflight_r;
    logic                inflight_last_r;
    logic [DATA_W-1:0]   fifo_data_r [2];
    logic                fifo_last_r [2];
    logic                wr_ptr_r;
    logic                rd_ptr_r;
    logic [1:0]          occ_r;

    logic                push_s;
    logic                pop_s;
    logic [2:0]          committed_s;
    logic                credit_s;
    logic                rd_en_s;
    logic                done_s;

`ifdef READOUT_BITREV_EN
    // Mirror the bits of a bank index (bit 0 <-> bit ADDR_W-1).
    function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] value);
        logic [ADDR_W-1:0] result;
        for (int i = 0; i < ADDR_W; i++) begin
            result[i] = value[ADDR_W-1-i];
        end
        return result;
    endfunction
`endif

    // Credit, read-issue and completion decode from the registered state.
    always_comb begin
        push_s      = inflight_r;
        pop_s       = (occ_r != 2'd0) && m_ready;
        // Entries that stay committed once this cycle's pop completes. A pop
        // frees its slot in the same cycle, which keeps a full-rate stream
        // running at one beat per clock.
        committed_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        credit_s    = (committed_s < 3'd2);
        if (state_r == ISSUE) begin
            rd_en_s = credit_s;
        end else begin
            rd_en_s = 1'b0;
        end
        if ((state_r == DRAIN) && pop_s) begin
            done_s = fifo_last_r[rd_ptr_r];
        end else begin
            done_s = 1'b0;
        end
    end

    // Pass sequencing: IDLE -> ISSUE (one read per credit) -> DRAIN until the last beat leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            issue_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r     <= ISSUE;
                        issue_cnt_r <= '0;
                    end
                end
                ISSUE: begin
                    if (rd_en_s) begin
                        issue_cnt_r <= issue_cnt_r + ADDR_W'(1);
                        if (issue_cnt_r == LAST_IDX) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (done_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    issue_cnt_r <= '0;
                end
            endcase
        end
    end

    // Track the single bank read in flight and whether it is the final index of the pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            inflight_r      <= rd_en_s;
            inflight_last_r <= rd_en_s && (issue_cnt_r == LAST_IDX);
        end
    end

    // 2-entry output buffer: capture rd_data one cycle after rd_en, pop on each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_r[i] <= '0;
                fifo_last_r[i] <= 1'b0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= rd_data;
                fifo_last_r[wr_ptr_r] <= inflight_last_r;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign busy    = (state_r != IDLE);
    assign done    = done_s;
    assign rd_en   = rd_en_s;
`ifdef READOUT_BITREV_EN
    assign rd_addr = bit_reverse(issue_cnt_r);
`else
    assign rd_addr = issue_cnt_r;
`endif
    assign m_valid = (occ_r != 2'd0);
    assign m_data  = fifo_data_r[rd_ptr_r];
    assign m_last  = (occ_r != 2'd0) && fifo_last_r[rd_ptr_r];

endmodule
